aes_key_sched_iter: RTL

AES_KEY_SCHED_ITER -- requirements
Module: aes_key_sched_iter

---
 rtl/aes_key_sched_iter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_sched_iter.sv
// aes_key_sched_iter
// Iterative AES key expansion. It produces one 32-bit schedule word per cycle
// and packs every four words into a round key. Round keys leave through a
// small output FIFO.
// Optional feature macro: AES_KEY_SCHED_256_EN. When it is defined, AES-256
// is supported and the word window is 8 deep. When it is not defined, key_len=2
// is rejected as illegal and the window is 6 deep.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds valid and its payload stable until that edge, and
// ready never depends on valid.
module aes_key_sched_iter #(
   parameter int         OUT_DEPTH = 2,
   parameter logic [7:0] RCON_INIT = 8'h01
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [1:0]   key_len,
   input  logic [255:0] key,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk,
   output logic [3:0]   rk_idx,
   output logic         rk_last,
   output logic         busy,
   output logic         err,
   output logic [1:0]   state_dbg
);

`ifdef AES_KEY_SCHED_256_EN
   localparam int   WIN_DEPTH = 8;
   localparam logic LEN256_OK = 1'b1;
`else
   localparam int   WIN_DEPTH = 6;
   localparam logic LEN256_OK = 1'b0;
`endif

   localparam int PW = $clog2(OUT_DEPTH);
   localparam logic [PW:0] FIFO_FULL_CNT = (PW+1)'(OUT_DEPTH);
   localparam int EW = 133;  // {rk[127:0], idx[3:0], last}

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_EXPAND = 2'd2;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // S-box entry x sits (255-x) bytes above bit 0, and (255-x) is ~x.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [1:0]    state;
   logic [255:0]  key_reg;      // key words still to be emitted, w[next] at top
   logic [31:0]   win [WIN_DEPTH]; // win[0] = w[i-1], win[Nk-1] = w[i-Nk]
   logic [2:0]    pos;          // i mod Nk for the word being generated
   logic [2:0]    nk_m1;
   logic [3:0]    nr;
   logic [5:0]    word_cnt;     // index i of the word being generated
   logic [5:0]    total_m1;
   logic [7:0]    rcon;
   logic [95:0]   acc;          // first three words of the current round key
   logic          err_q;

   logic [EW-1:0] fifo_mem [OUT_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   fifo_cnt;

   logic          key_accept, len_ok, fifo_full, fifo_push, fifo_pop, gen_en;
   logic [31:0]   temp, new_word;
   logic [EW-1:0] push_data, head;

   // Handshake qualifiers and the generation enable.
   always_comb begin
      key_accept = key_valid && key_ready;
      len_ok     = (key_len == 2'd0) || (key_len == 2'd1) || (LEN256_OK && key_len == 2'd2);
      fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
      fifo_pop   = rk_valid && rk_ready;
      // A word is produced only when the FIFO can take it. That includes a
      // full FIFO that is being popped in the same cycle.
      gen_en     = (state != ST_IDLE) && (!fifo_full || fifo_pop);
      fifo_push  = gen_en && (word_cnt[1:0] == 2'b11);
   end

   // Next schedule word. It is a raw key word during LOAD and the FIPS-197
   // recurrence during EXPAND.
   always_comb begin
      temp = win[0];
      if (pos == 3'd0)
         temp = sub_word({win[0][23:0], win[0][31:24]}) ^ {rcon, 24'h000000};
      else if (nk_m1 == 3'd7 && pos == 3'd4)
         temp = sub_word(win[0]);
      new_word  = (state == ST_LOAD) ? key_reg[255:224] : (win[nk_m1] ^ temp);
      push_data = {acc, new_word, word_cnt[5:2], (word_cnt[5:2] == nr)};
   end

   // FSM, word window, counters, round constant and assembler.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         key_reg  <= '0;
         pos      <= '0;
         nk_m1    <= '0;
         nr       <= '0;
         word_cnt <= '0;
         total_m1 <= '0;
         rcon     <= '0;
         acc      <= '0;
         err_q    <= 1'b0;
         for (int k = 0; k < WIN_DEPTH; k++) win[k] <= '0;
      end else begin
         err_q <= key_accept && !len_ok;
         if (state == ST_IDLE) begin
            if (key_accept && len_ok) begin
               state    <= ST_LOAD;
               key_reg  <= key;
               rcon     <= RCON_INIT;
               pos      <= '0;
               word_cnt <= '0;
               case (key_len)
                  2'd0:    begin nk_m1 <= 3'd3; nr <= 4'd10; total_m1 <= 6'd43; end
                  2'd1:    begin nk_m1 <= 3'd5; nr <= 4'd12; total_m1 <= 6'd51; end
                  default: begin nk_m1 <= 3'd7; nr <= 4'd14; total_m1 <= 6'd59; end
               endcase
            end
         end else if (gen_en) begin
            win[0] <= new_word;
            for (int k = WIN_DEPTH - 1; k > 0; k--) win[k] <= win[k-1];
            acc      <= {acc[63:0], new_word};
            pos      <= (pos == nk_m1) ? 3'd0 : pos + 3'd1;
            word_cnt <= word_cnt + 6'd1;
            if (state == ST_LOAD) begin
               key_reg <= {key_reg[223:0], 32'h00000000};
               if (word_cnt == {3'b000, nk_m1}) state <= ST_EXPAND;
            end else begin
               if (pos == 3'd0) rcon <= xtime(rcon);
               if (word_cnt == total_m1) state <= ST_IDLE;
            end
         end
      end
   end

   // Output FIFO pointers and occupancy. A reset flushes the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // FIFO storage. It has no reset because entries are only read when the count says so.
   always_ff @(posedge clk) begin
      if (fifo_push) fifo_mem[wr_ptr] <= push_data;
   end

   // Outputs. The round-key fields read as zero while no key is available.
   always_comb begin
      head      = fifo_mem[rd_ptr];
      rk_valid  = (fifo_cnt != '0);
      rk        = rk_valid ? head[132:5] : '0;
      rk_idx    = rk_valid ? head[4:1] : '0;
      rk_last   = rk_valid && head[0];
      key_ready = (state == ST_IDLE) && (fifo_cnt == '0);
      busy      = (state != ST_IDLE);
      err       = err_q;
      state_dbg = state;
   end

endmodule
